// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared definitions for the reorder buffer and the units that talk to it:
//   - instruction class codes carried on r_ins_type (Rtype/Stype/Btype/Jtype)
//   - default index width of the buffer
//   - operand query result record
//   - helper that decides whether a retiring entry writes the regfile
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int ROB_R = 4;

    typedef enum logic [1:0] {
        RTYPE = 2'd0,   // register-writing ALU/load ops, lui/auipc
        STYPE = 2'd1,   // stores, executed by the LSB when at head
        BTYPE = 2'd2,   // conditional branches, checked at commit
        JTYPE = 2'd3    // jal/jalr, rd = pc+4 known at dispatch
    } ins_type_e;

    typedef struct packed {
        logic        ready;
        logic [31:0] val;
    } query_t;

    // Stores and branches never touch the regfile; x0 is never written.
    function automatic logic writes_rd(ins_type_e t, logic [4:0] rd);
        return ((t == RTYPE) || (t == JTYPE)) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every reorder-buffer connection except clock, reset and enable.
//   dispatch  : r_is_ins, r_ins_pc, r_ins_already_done, r_ins_result, r_ins_rd,
//               r_ins_pred_jmp, r_another_addr, r_ins_type  -> ROB
//               rob_full, rob_free_id                       <- ROB
//   flush     : rob_clear, rob_redirect_pc                  <- ROB
//   writeback : alu_ready, alu_rob_id, alu_val, alu_jmp,
//               lsb_ready, lsb_rob_id, lsb_val              -> ROB
//   commit    : commit_reg_en, commit_rd, commit_val, commit_rob_id <- ROB
//   store     : rob_head_store, rob_head_id                 <- ROB
//   query     : rob_q1_id, rob_q2_id -> ROB; rob_qN_ready, rob_qN_val <- ROB
// Modport slave is the buffer itself; master is the surrounding core/bench.
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int ROB_BITS = 4
);
    logic                r_is_ins;
    logic [31:0]         r_ins_pc;
    logic                r_ins_already_done;
    logic [31:0]         r_ins_result;
    logic [4:0]          r_ins_rd;
    logic                r_ins_pred_jmp;
    logic [31:0]         r_another_addr;
    logic [1:0]          r_ins_type;
    logic                rob_full;
    logic [ROB_BITS-1:0] rob_free_id;

    logic                rob_clear;
    logic [31:0]         rob_redirect_pc;

    logic                alu_ready;
    logic [ROB_BITS-1:0] alu_rob_id;
    logic [31:0]         alu_val;
    logic                alu_jmp;
    logic                lsb_ready;
    logic [ROB_BITS-1:0] lsb_rob_id;
    logic [31:0]         lsb_val;

    logic                commit_reg_en;
    logic [4:0]          commit_rd;
    logic [31:0]         commit_val;
    logic [ROB_BITS-1:0] commit_rob_id;

    logic                rob_head_store;
    logic [ROB_BITS-1:0] rob_head_id;

    logic [ROB_BITS-1:0] rob_q1_id;
    logic                rob_q1_ready;
    logic [31:0]         rob_q1_val;
    logic [ROB_BITS-1:0] rob_q2_id;
    logic                rob_q2_ready;
    logic [31:0]         rob_q2_val;

    modport master (
        output r_is_ins, r_ins_pc, r_ins_already_done, r_ins_result, r_ins_rd,
               r_ins_pred_jmp, r_another_addr, r_ins_type,
               alu_ready, alu_rob_id, alu_val, alu_jmp,
               lsb_ready, lsb_rob_id, lsb_val,
               rob_q1_id, rob_q2_id,
        input  rob_full, rob_free_id, rob_clear, rob_redirect_pc,
               commit_reg_en, commit_rd, commit_val, commit_rob_id,
               rob_head_store, rob_head_id,
               rob_q1_ready, rob_q1_val, rob_q2_ready, rob_q2_val
    );

    modport slave (
        input  r_is_ins, r_ins_pc, r_ins_already_done, r_ins_result, r_ins_rd,
               r_ins_pred_jmp, r_another_addr, r_ins_type,
               alu_ready, alu_rob_id, alu_val, alu_jmp,
               lsb_ready, lsb_rob_id, lsb_val,
               rob_q1_id, rob_q2_id,
        output rob_full, rob_free_id, rob_clear, rob_redirect_pc,
               commit_reg_en, commit_rd, commit_val, commit_rob_id,
               rob_head_store, rob_head_id,
               rob_q1_ready, rob_q1_val, rob_q2_ready, rob_q2_val
    );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer of 2**ROB_BITS entries.
//   clk_in  : clock
//   rst_in  : synchronous active-high reset
//   rdy_in  : global enable, low freezes every register
//   bus     : reorder_buffer_if.slave (dispatch, writeback, commit, store
//             release, flush and operand query signals)
// Entries are allocated at tail from the decoder, marked ready by ALU/LSB
// broadcasts, and retired one per cycle from head. A branch whose resolved
// direction differs from the prediction raises rob_clear for one cycle with
// the redirect address; the following cycle empties the buffer.
// -----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_BITS = ROB_R
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    reorder_buffer_if.slave   bus
);

    localparam int ROB_SIZE = 2 ** ROB_BITS;

    typedef logic [ROB_BITS-1:0] idx_t;
    typedef logic [ROB_BITS:0]   cnt_t;

    // RUN: normal operation. CLEAR: rob_clear asserted, buffer flushes at
    // the end of this cycle.
    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Entry storage. Only busy is reset; the other fields are qualified by it.
    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] pred_jmp_q;
    logic [ROB_SIZE-1:0] act_jmp_q;
    ins_type_e           type_q    [ROB_SIZE];
    logic [4:0]          rd_q      [ROB_SIZE];
    logic [31:0]         val_q     [ROB_SIZE];
    logic [31:0]         another_q [ROB_SIZE];

    idx_t head_q, tail_q;
    cnt_t count_q, count_d;

    logic        commit_reg_en_q;
    logic [4:0]  commit_rd_q;
    logic [31:0] commit_val_q;
    idx_t        commit_rob_id_q;
    logic [31:0] redirect_pc_q;

    logic do_commit, do_alloc, mispredict;
    logic alu_hit, lsb_hit;
    query_t q1, q2;

    // Broadcasts land only on busy entries still waiting for a result.
    assign alu_hit = bus.alu_ready && busy_q[bus.alu_rob_id] && !ready_q[bus.alu_rob_id];
    assign lsb_hit = bus.lsb_ready && busy_q[bus.lsb_rob_id] && !ready_q[bus.lsb_rob_id];

    // Operand lookup with same-cycle forwarding from either broadcast bus.
    function automatic query_t query_entry(idx_t id);
        query_t r;
        r.ready = 1'b0;
        r.val   = val_q[id];
        if (busy_q[id]) begin
            if (ready_q[id]) begin
                r.ready = 1'b1;
            end else if (rdy_in && bus.alu_ready && (bus.alu_rob_id == id)) begin
                r.ready = 1'b1;
                r.val   = bus.alu_val;
            end else if (rdy_in && bus.lsb_ready && (bus.lsb_rob_id == id)) begin
                r.ready = 1'b1;
                r.val   = bus.lsb_val;
            end
        end
        return r;
    endfunction

    always_comb begin
        q1 = query_entry(bus.rob_q1_id);
        q2 = query_entry(bus.rob_q2_id);
    end

    // Commit decision and flush sequencing.
    always_comb begin
        state_d    = state_q;
        do_commit  = 1'b0;
        do_alloc   = 1'b0;
        mispredict = 1'b0;
        if (state_q == S_CLEAR) begin
            state_d = S_RUN;
        end else begin
            do_alloc = bus.r_is_ins;
            // Uses the registered ready bit, so a result written back this
            // cycle retires next cycle at the earliest.
            if ((count_q != '0) && busy_q[head_q] && ready_q[head_q]) begin
                do_commit = 1'b1;
                if ((type_q[head_q] == BTYPE) &&
                    (act_jmp_q[head_q] != pred_jmp_q[head_q])) begin
                    mispredict = 1'b1;
                    state_d    = S_CLEAR;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_RUN;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Control: pointers, occupancy, commit/redirect outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            commit_reg_en_q <= 1'b0;
            commit_rd_q     <= '0;
            commit_val_q    <= '0;
            commit_rob_id_q <= '0;
            redirect_pc_q   <= '0;
        end else if (rdy_in) begin
            if (state_q == S_CLEAR) begin
                head_q          <= '0;
                tail_q          <= '0;
                count_q         <= '0;
                busy_q          <= '0;
                commit_reg_en_q <= 1'b0;
                commit_rd_q     <= '0;
                commit_val_q    <= '0;
                commit_rob_id_q <= '0;
                redirect_pc_q   <= '0;
            end else begin
                commit_reg_en_q <= do_commit && writes_rd(type_q[head_q], rd_q[head_q]);
                if (do_commit) begin
                    commit_rd_q     <= rd_q[head_q];
                    commit_val_q    <= val_q[head_q];
                    commit_rob_id_q <= head_q;
                    busy_q[head_q]  <= 1'b0;
                    head_q          <= head_q + idx_t'(1);
                    if (mispredict) begin
                        redirect_pc_q <= another_q[head_q];
                    end
                end
                // Allocation after the commit clear so a reused slot ends busy.
                if (do_alloc) begin
                    busy_q[tail_q] <= 1'b1;
                    tail_q         <= tail_q + idx_t'(1);
                end
                count_q <= count_d;
            end
        end
    end

    // Data: entry payload, never reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && (state_q == S_RUN)) begin
            if (alu_hit) begin
                ready_q[bus.alu_rob_id] <= 1'b1;
                val_q[bus.alu_rob_id]   <= bus.alu_val;
                if (type_q[bus.alu_rob_id] == BTYPE) begin
                    act_jmp_q[bus.alu_rob_id] <= bus.alu_jmp;
                end
            end
            if (lsb_hit) begin
                ready_q[bus.lsb_rob_id] <= 1'b1;
                val_q[bus.lsb_rob_id]   <= bus.lsb_val;
            end
            if (do_alloc) begin
                ready_q[tail_q]    <= bus.r_ins_already_done;
                val_q[tail_q]      <= bus.r_ins_result;
                type_q[tail_q]     <= ins_type_e'(bus.r_ins_type);
                rd_q[tail_q]       <= bus.r_ins_rd;
                pred_jmp_q[tail_q] <= bus.r_ins_pred_jmp;
                act_jmp_q[tail_q]  <= 1'b0;
                another_q[tail_q]  <= bus.r_another_addr;
            end
        end
    end

    assign bus.rob_free_id     = tail_q;
    assign bus.rob_full        = (count_q >= cnt_t'(ROB_SIZE - 1));
    assign bus.rob_clear       = (state_q == S_CLEAR);
    assign bus.rob_redirect_pc = redirect_pc_q;
    assign bus.rob_head_id     = head_q;
    assign bus.rob_head_store  = busy_q[head_q] && (type_q[head_q] == STYPE) &&
                                 !ready_q[head_q] && (state_q != S_CLEAR);
    assign bus.commit_reg_en   = commit_reg_en_q;
    assign bus.commit_rd       = commit_rd_q;
    assign bus.commit_val      = commit_val_q;
    assign bus.commit_rob_id   = commit_rob_id_q;
    assign bus.rob_q1_ready    = q1.ready;
    assign bus.rob_q1_val      = q1.val;
    assign bus.rob_q2_ready    = q2.ready;
    assign bus.rob_q2_val      = q2.val;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer. It receives the registered dispatch stream from the decoder and results from the ALU/RS and LSB broadcast buses.
- Retires one instruction per cycle to the regfile.
- Releases stores at head to the LSB.
- Detects branch mispredicts at commit; raises rob_clear and the redirect PC for fetch.

Parameters:
ROB_BITS, 4, index width; depth ROB_SIZE = 2**ROB_BITS; must match `ROB_R in const.v

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = hold all state
r_is_ins  in  1  dispatch valid (from decoder, registered there)
r_ins_pc  in  32  instruction PC
r_ins_already_done  in  1  result known at dispatch (lui/auipc/jal/jalr)
r_ins_result  in  32  result when already_done
r_ins_rd  in  5  destination register
r_ins_pred_jmp  in  1  predicted taken
r_another_addr  in  32  not-predicted path address
r_ins_type  in  2  `Rtype/`Stype/`Btype/`Jtype
rob_full  out  1  stall request to decoder
rob_free_id  out  ROB_BITS  tail index, tag for the instruction dispatched this cycle
rob_clear  out  1  flush pulse to all units
rob_redirect_pc  out  32  fetch restart address, valid with rob_clear
alu_ready  in  1  ALU broadcast valid
alu_rob_id  in  ROB_BITS  ALU broadcast tag
alu_val  in  32  ALU result
alu_jmp  in  1  branch actually taken (Btype only)
lsb_ready  in  1  LSB broadcast valid
lsb_rob_id  in  ROB_BITS  LSB tag
lsb_val  in  32  load data (ignored for stores)
commit_reg_en  out  1  regfile write
commit_rd  out  5  regfile write register
commit_val  out  32  regfile write data
commit_rob_id  out  ROB_BITS  tag retiring; regfile clears the matching dependency
rob_head_store  out  1  head is a busy, not-ready Stype entry; LSB may execute it
rob_head_id  out  ROB_BITS  head index
rob_q1_id  in  ROB_BITS  operand query 1
rob_q1_ready  out  1  queried entry is ready (combinational)
rob_q1_val  out  32  queried entry value (combinational)
rob_q2_id  in  ROB_BITS  operand query 2
rob_q2_ready  out  1  queried entry is ready (combinational)
rob_q2_val  out  32  queried entry value (combinational)

Behaviour:
- Per-entry state: busy, ready, type, rd, pc, val, pred_jmp, another_addr, actual_jmp. Pointers: head, tail, count (ROB_BITS+1 bits).
- Reset, and the cycle after rob_clear: head = tail = count = 0; all busy = 0. All outputs 0, including rob_free_id, rob_redirect_pc and all commit_* outputs.
- rdy_in = 0: no state change; registered outputs hold.
- Free tag: rob_free_id = tail, combinational from the register.
- Allocation: on r_is_ins, entry[tail] is written and tail wraps modulo ROB_SIZE.
  - busy = 1.
  - ready = r_ins_already_done; val = r_ins_result.
- Full: rob_full = (count >= ROB_SIZE-1), computed from registered count. This leaves room for one dispatch already in flight from the decoder.
- Writeback:
  - alu_ready and lsb_ready can both fire in one cycle, with different ids.
  - Target entry gets ready = 1 and val.
  - ALU writeback to a Btype entry also latches actual_jmp = alu_jmp.
  - Writeback to a non-busy entry, or to an entry already ready, is ignored.
- Store at head: rob_head_store = busy[head] & type==`Stype & !ready[head] & !rob_clear.
- Commit: when count > 0, busy[head] and ready[head] (registered ready), entry[head] retires and head advances. One commit per cycle.
  - Writeback and commit of the same entry in the same cycle are not allowed; commit happens the next cycle.
  - commit_* outputs are registered; commit_reg_en pulses for 1 cycle.
  - commit_reg_en = 1 only for `Rtype/`Jtype with rd != 0.
  - commit_rob_id = head index is always presented with the commit.
  - `Stype and `Btype entries never write rd.
- Mispredict: a `Btype commit with actual_jmp != pred_jmp registers rob_clear = 1 for exactly one cycle, with rob_redirect_pc = another_addr.
  - The next cycle flushes the buffer.
  - A correctly predicted branch commits silently.
- Simultaneous allocate and commit: count unchanged, both pointers advance.
- Allocation in a cycle where rob_clear = 1 is dropped; the decoder also clears.
- Wrap-around: pointer ROB_SIZE-1 wraps to 0. count distinguishes full from empty.
- Query ports: ready = busy & ready bit, with val taken from the entry. A same-cycle writeback to the queried id is forwarded (ready = 1, val = broadcast value).
- `Jtype writes rd = pc+4 from dispatch. Jalr target resolution is outside this block; the ROB ignores broadcasts to already_done entries.

Decomposition:
- const.v: `ROB_R, ROB_SIZE, and the type codes `Rtype/`Stype/`Btype/`Jtype, shared with the decoder, RS and LSB.
- No sub-module: entry arrays, pointer logic and the commit FSM stay in one file. Query forwarding is a local function.

Test Plan:
- Reset, then dispatch lui x5 (already_done, result 0x12345000) -> next cycle commit_reg_en = 1, rd = 5, val = 0x12345000, commit_rob_id = 0.
- Dispatch 3 Rtype tags 0,1,2; ALU writeback order 2,1,0 -> commits in order 0,1,2 on 3 consecutive cycles after tag 0 is ready.
- Dispatch 15 entries without writeback (ROB_SIZE = 16) -> rob_full = 1 once count = 15. Then write back head and commit -> count = 14, rob_full deasserts; tail wraps 15 -> 0.
- Btype, pred_jmp = 0, another_addr = 0x100, alu_jmp = 1 -> one-cycle rob_clear with redirect 0x100. Next cycle count = 0, rob_free_id = 0, younger entries never commit.
- Stype at head -> rob_head_store = 1, rob_head_id = head. lsb_ready on that id -> rob_head_store drops, commit with commit_reg_en = 0.
- Query tag 3 while ALU broadcasts tag 3 with value 7 -> rob_q1_ready = 1, rob_q1_val = 7 in the same cycle.
- rdy_in = 0 during a pending commit -> no commit, pointers frozen. Commit occurs once rdy_in returns to 1.
